// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared types for the single-port RAM with March C- BIST.
// Holds the FSM state enum and the March element table.
package ram_bist_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      CHECK,
      DONE
   } bist_state_t;

   localparam int NUM_ELEM = 6;

   typedef struct packed {
      logic dir_down;
      logic two_op;
      logic rd_only;
      logic rd_exp;
      logic wr_val;
   } march_elem_t;

   // Index past the last element decodes to all zeros.
   function automatic march_elem_t march_elem(input logic [2:0] idx);
      march_elem_t e;
      e = '0;
      case (idx)
         3'd0: e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
         3'd1: e = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
         3'd2: e = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
         3'd3: e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
         3'd4: e = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
         3'd5: e = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
         default: e = '0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/sp_ram_core.sv
// sp_ram_core: clocked single-port array with registered read,
// read-before-write, and a stuck-at-1 fault mux on the read path.
module sp_ram_core
   import ram_bist_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int WIDTH  = 8,
   parameter int AWIDTH = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic              rd_func,
   input  logic [AWIDTH-1:0] addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              fault_inj,
   input  logic [AWIDTH-1:0] fault_addr,
   output logic [WIDTH-1:0]  rd_data,
   output logic [WIDTH-1:0]  bist_data
);

   localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             in_range;
   logic [WIDTH-1:0] rd_val;

   // Raw read value: out-of-range reads give 0, fault forces bit 0 high.
   always_comb begin
      in_range = ({1'b0, addr} < DEPTH_W);
      rd_val   = '0;
      if (in_range) rd_val = mem[addr];
      if (fault_inj && (addr == fault_addr)) rd_val[0] = 1'b1;
   end

   // Array write; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en && in_range) mem[addr] <= wr_data;
   end

   // Separate read registers keep BIST reads off the functional port.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data   <= '0;
         bist_data <= '0;
      end else if (rd_en) begin
         if (rd_func) rd_data <= rd_val;
         else         bist_data <= rd_val;
      end
   end

endmodule

// File: rtl/ram_bist_sp.sv
// ram_bist_sp: single-port RAM with a March C- self-test controller.
// BIST owns the array in RUN/CHECK; functional port otherwise.
module ram_bist_sp
   import ram_bist_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int WIDTH  = 8,
   parameter int AWIDTH = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [AWIDTH-1:0] addr,
   input  logic [WIDTH-1:0]  wr_data,
   output logic [WIDTH-1:0]  rd_data,
   input  logic              bist_start,
   output logic              bist_busy,
   output logic              bist_done,
   output logic              bist_fail,
   output logic [AWIDTH-1:0] bist_fail_addr,
   output logic [2:0]        bist_fail_elem,
   input  logic              fault_inj,
   input  logic [AWIDTH-1:0] fault_addr
);

   localparam logic [AWIDTH-1:0] ADDR_MAX = AWIDTH'(DEPTH - 1);
   localparam logic [2:0]        ELEM_MAX = 3'(NUM_ELEM - 1);

   bist_state_t state_q, state_d;

   logic [2:0]        elem_q;
   logic [AWIDTH-1:0] addr_q;
   logic              phase_q;

   march_elem_t me, next_me;

   logic              func_en;
   logic              start_ok;
   logic              op_last;
   logic              addr_end;
   logic              final_op;
   logic              bist_rd;
   logic              bist_wr;

   logic              core_wr;
   logic              core_rd;
   logic [AWIDTH-1:0] core_addr;
   logic [WIDTH-1:0]  core_wdata;
   logic [WIDTH-1:0]  bist_data;

   logic              cmp_valid;
   logic [WIDTH-1:0]  cmp_exp;
   logic [AWIDTH-1:0] cmp_addr;
   logic [2:0]        cmp_elem;

   // Current March element decode and per-cycle BIST operation.
   always_comb begin
      me       = march_elem(elem_q);
      next_me  = march_elem(elem_q + 3'd1);
      func_en  = (state_q == IDLE) || (state_q == DONE);
      start_ok = bist_start && func_en;
      op_last  = !me.two_op || phase_q;
      addr_end = me.dir_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
      bist_rd  = (state_q == RUN) &&
                 (me.rd_only || (me.two_op && !phase_q));
      bist_wr  = (state_q == RUN) && !me.rd_only && op_last;
      final_op = (state_q == RUN) && op_last && addr_end &&
                 (elem_q == ELEM_MAX);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; start is only honoured from IDLE or DONE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start_ok) state_d = RUN;
         RUN:   if (final_op) state_d = CHECK;
         CHECK: state_d = DONE;
         DONE:  if (start_ok) state_d = RUN;
      endcase
   end

   // Element / address / op-phase sequencing through the March test.
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         elem_q  <= '0;
         addr_q  <= '0;
         phase_q <= 1'b0;
      end else if (state_q == RUN) begin
         if (!op_last) begin
            phase_q <= 1'b1;
         end else begin
            phase_q <= 1'b0;
            if (addr_end) begin
               elem_q <= elem_q + 3'd1;
               addr_q <= next_me.dir_down ? ADDR_MAX : '0;
            end else if (me.dir_down) begin
               addr_q <= addr_q - 1'b1;
            end else begin
               addr_q <= addr_q + 1'b1;
            end
         end
      end
   end

   // Arbitrate the array between the functional port and BIST.
   always_comb begin
      core_wr    = func_en ? wr_en : bist_wr;
      core_rd    = func_en ? rd_en : bist_rd;
      core_addr  = func_en ? addr : addr_q;
      core_wdata = func_en ? wr_data : {WIDTH{me.wr_val}};
   end

   sp_ram_core #(
      .DEPTH  (DEPTH),
      .WIDTH  (WIDTH),
      .AWIDTH (AWIDTH)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (core_wr),
      .rd_en      (core_rd),
      .rd_func    (func_en),
      .addr       (core_addr),
      .wr_data    (core_wdata),
      .fault_inj  (fault_inj),
      .fault_addr (fault_addr),
      .rd_data    (rd_data),
      .bist_data  (bist_data)
   );

   // Pipelined compare and sticky status; first mismatch wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         bist_busy      <= 1'b0;
         bist_done      <= 1'b0;
         bist_fail      <= 1'b0;
         bist_fail_addr <= '0;
         bist_fail_elem <= '0;
         cmp_valid      <= 1'b0;
         cmp_exp        <= '0;
         cmp_addr       <= '0;
         cmp_elem       <= '0;
      end else begin
         cmp_valid <= bist_rd;
         if (bist_rd) begin
            cmp_exp  <= {WIDTH{me.rd_exp}};
            cmp_addr <= addr_q;
            cmp_elem <= elem_q;
         end
         if (start_ok) begin
            bist_busy      <= 1'b1;
            bist_done      <= 1'b0;
            bist_fail      <= 1'b0;
            bist_fail_addr <= '0;
            bist_fail_elem <= '0;
         end else begin
            if ((state_q == DONE) && bist_busy) begin
               bist_busy <= 1'b0;
               bist_done <= 1'b1;
            end
            if (cmp_valid && (bist_data != cmp_exp) && !bist_fail) begin
               bist_fail      <= 1'b1;
               bist_fail_addr <= cmp_addr;
               bist_fail_elem <= cmp_elem;
            end
         end
      end
   end

endmodule

// File: doc/ram_bist_sp.md
Name: ram_bist_sp

Overview:
- Synchronous single-port RAM, parametrised in depth and width, with a built-in March C- self-test engine.
- Successor to the team's write-strobe-clocked test RAM: adds a real clock, synchronous reset, registered reads, a BIST controller and stuck-at fault injection.
- Sits behind the JTAG TAP as the design-under-test; BIST start and status map onto a JTAG user data register.

Parameters:
- DEPTH, 16, number of words (≥2)
- WIDTH, 8, bits per word (≥1)
- AWIDTH, $clog2(DEPTH), address width

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  functional write strobe
- rd_en  in  1  functional read strobe
- addr  in  AWIDTH  functional address
- wr_data  in  WIDTH  write data
- rd_data  out  WIDTH  registered read data
- bist_start  in  1  one-cycle start request
- bist_busy  out  1  BIST running
- bist_done  out  1  sticky: BIST finished
- bist_fail  out  1  sticky: at least one mismatch
- bist_fail_addr  out  AWIDTH  address of first mismatch
- bist_fail_elem  out  3  March element index (0-5) of first mismatch
- fault_inj  in  1  enable stuck-at-1 on bit 0 of word fault_addr, read path only
- fault_addr  in  AWIDTH  injected fault location

Behaviour:
- Reset (rst=1 at a clk edge):
  - Registers after the edge: rd_data=0, bist_busy=0, bist_done=0, bist_fail=0, bist_fail_addr=0, bist_fail_elem=0, FSM in IDLE.
  - Memory contents are not reset.
  - Reset during RUN aborts the test and clears all status in the same edge.
- Functional access (FSM IDLE or DONE only):
  - Read latency 1: rd_en at edge N gives mem[addr] on rd_data after edge N. rd_data holds otherwise.
  - Write takes effect at the edge.
  - wr_en and rd_en together at the same addr: rd_data returns old contents (read-before-write).
  - Out-of-range addr (DEPTH not a power of 2): write ignored, read returns 0.
- Fault injection: when fault_inj=1, any read of fault_addr (functional or BIST) returns bit 0 forced to 1. Stored data is unchanged.
- FSM states and transitions:
  - IDLE → RUN on bist_start.
  - RUN → CHECK after the last operation.
  - CHECK → DONE.
  - DONE → RUN on bist_start.
  - bist_start is ignored in RUN and CHECK.
- March C- sequence, elements 0-5, background all-0/all-1:
  - E0 ⇑(w0), E1 ⇑(r0,w1), E2 ⇑(r1,w0), E3 ⇓(r0,w1), E4 ⇓(r1,w0), E5 ⇑(r0).
  - ⇑ = addr 0..DEPTH-1, ⇓ = addr DEPTH-1..0.
  - One operation per cycle; r and w to the same address take consecutive cycles.
  - Total 10·DEPTH operation cycles.
- Timing, with start sampled at edge T:
  - bist_busy=1 from after edge T through after edge T+10·DEPTH+1.
  - Operations are issued at edges T+1 .. T+10·DEPTH.
  - Each read is compared one cycle after it is issued (pipelined compare); the final compare happens in CHECK.
  - bist_done=1 after edge T+10·DEPTH+2 and stays high until the next accepted start or reset.
  - An accepted start clears done, fail, fail_addr and fail_elem.
- Fail capture:
  - On the first mismatch, latch fail_addr and fail_elem of the issuing read and set bist_fail.
  - Later mismatches do not update the captured fields.
  - The test always runs to completion, so timing is data-independent.
- BIST leaves memory all-0 on completion. Functional rd_data is not updated by BIST reads.

Decomposition:
- Package ram_bist_pkg:
  - bist_state_t enum {IDLE, RUN, CHECK, DONE}.
  - March element table: per element a direction bit, op count (1 or 2), read expect value and write value.
  - NUM_ELEM=6 constant.
- Sub-module sp_ram_core: clocked array, registered read port, read-before-write, fault-injection mux.
- Top: BIST FSM, address/element counters, and the arbitration mux between the functional and BIST paths.

Test Plan:
All scenarios use DEPTH=4, WIDTH=2.
1. Functional path, no fault: write 2'b10 to addr 3, then rd_en addr 3 → rd_data=2'b10 one cycle later. Simultaneous wr 2'b01 / rd at addr 3 → rd_data=2'b10, following read → 2'b01.
2. Clean BIST: bist_start pulse at edge T, fault_inj=0 →
   - busy high for edges T..T+41.
   - done=1 after edge T+42.
   - fail=0.
   - memory reads 0 at all addresses afterwards.
3. Stuck-at fault: fault_inj=1, fault_addr=2, run BIST → fail=1, fail_addr=2, fail_elem=1, done after edge T+42 (no early abort).
4. Start while busy: second bist_start at T+10 → ignored, done still after edge T+42. Functional wr_en during busy → memory unchanged.
5. Reset at T+20 mid-BIST → all status 0 next cycle, FSM IDLE. A new start runs a full 42-cycle test.
6. Re-run after fail: clear fault_inj, bist_start → fail, fail_addr and fail_elem cleared at start; final fail=0, done=1.
